// File: rtl/fft_wn_mul_pkg.sv
// Shared FFT defines: lane count, widths, Q8 scaling constants and the highest legal stage.
// The rounding constant is only consumed when FFT_ROUND_EN is defined.
package fft_wn_mul_pkg;

  localparam int FFT_WN_LEN    = 8;
  localparam int FFT_WN_WID    = 10;
  localparam int FFT_DAT_WID   = 16;
  localparam int FFT_STG_WID   = 3;
  localparam int FFT_Q_SHIFT   = 8;
  localparam int FFT_RND_CONST = 128;
  localparam int FFT_MAX_STAGE = 3;

endpackage

// File: rtl/fft_wn_mul_cmul_lane.sv
// One complex lane: registered partial products, then combine, Q8 scale and saturate.
// Build option FFT_ROUND_EN adds half an LSB before the shift (round half up).
module fft_cmul_lane
  import fft_wn_mul_pkg::*;
#(
  parameter int WN_WID  = FFT_WN_WID,
  parameter int DAT_WID = FFT_DAT_WID
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic signed [DAT_WID-1:0] xr,
  input  logic signed [DAT_WID-1:0] xi,
  input  logic signed [WN_WID-1:0]  wr,
  input  logic signed [WN_WID-1:0]  wi,
  output logic signed [DAT_WID-1:0] yr,
  output logic signed [DAT_WID-1:0] yi
);

  localparam int PW = DAT_WID + WN_WID;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DAT_WID+1){1'b0}}, {(DAT_WID-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [SW-1:0] s_re, s_im, r_re, r_im, q_re, q_im;

  function automatic logic signed [DAT_WID-1:0] sat(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] c;
    c = v;
    if (v > SAT_MAX) c = SAT_MAX;
    if (v < SAT_MIN) c = SAT_MIN;
    return c[DAT_WID-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_rr <= '0;
      p_ii <= '0;
      p_ri <= '0;
      p_ir <= '0;
    end else if (en) begin
      p_rr <= PW'(xr) * PW'(wr);
      p_ii <= PW'(xi) * PW'(wi);
      p_ri <= PW'(xr) * PW'(wi);
      p_ir <= PW'(xi) * PW'(wr);
    end
  end

  always_comb begin
    s_re = SW'(p_rr) - SW'(p_ii);
    s_im = SW'(p_ri) + SW'(p_ir);
`ifdef FFT_ROUND_EN
    r_re = s_re + SW'(FFT_RND_CONST);
    r_im = s_im + SW'(FFT_RND_CONST);
`else
    r_re = s_re;
    r_im = s_im;
`endif
    q_re = r_re >>> FFT_Q_SHIFT;
    q_im = r_im >>> FFT_Q_SHIFT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yr <= '0;
      yi <= '0;
    end else if (en) begin
      yr <= sat(q_re);
      yi <= sat(q_im);
    end
  end

endmodule

// File: rtl/fft_wn_mul.sv
// Three-stage twiddle multiplier: S0 data/stage, S1 partial products, S2 scaled products.
// Define FFT_ROUND_EN for round-half-up scaling instead of truncation.
module fft_wn_mul
  import fft_wn_mul_pkg::*;
#(
  parameter int WN_LEN  = FFT_WN_LEN,
  parameter int WN_WID  = FFT_WN_WID,
  parameter int DAT_WID = FFT_DAT_WID,
  parameter int STG_WID = FFT_STG_WID
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_vld_i,
  output logic                      in_rdy_o,
  input  logic [STG_WID-1:0]        stage_i,
  input  logic [WN_LEN*DAT_WID-1:0] dat_re_i,
  input  logic [WN_LEN*DAT_WID-1:0] dat_im_i,
  output logic [STG_WID-1:0]        fft_stage_o,
  input  logic [WN_LEN*WN_WID-1:0]  fft_wn_re_i,
  input  logic [WN_LEN*WN_WID-1:0]  fft_wn_im_i,
  output logic                      out_vld_o,
  input  logic                      out_rdy_i,
  output logic [WN_LEN*DAT_WID-1:0] out_re_o,
  output logic [WN_LEN*DAT_WID-1:0] out_im_o,
  output logic                      err_o
);

  logic                      stall, accept, stage_ok;
  logic                      s0_vld, s1_vld;
  logic [WN_LEN*DAT_WID-1:0] s0_re, s0_im;

  // A stalled output freezes every stage at once, so in_rdy is simply the inverse of stall.
  assign stall    = out_vld_o && !out_rdy_i;
  assign in_rdy_o = !stall;
  assign accept   = in_vld_i && in_rdy_o;
  assign stage_ok = (fft_stage_o <= STG_WID'(FFT_MAX_STAGE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_vld      <= 1'b0;
      fft_stage_o <= '0;
      s0_re       <= '0;
      s0_im       <= '0;
    end else if (!stall) begin
      s0_vld      <= in_vld_i;
      fft_stage_o <= stage_i;
      s0_re       <= dat_re_i;
      s0_im       <= dat_im_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      out_vld_o <= 1'b0;
    end else if (!stall) begin
      s1_vld    <= s0_vld;
      out_vld_o <= s1_vld;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_o <= 1'b0;
    end else if (accept && (stage_i > STG_WID'(FFT_MAX_STAGE))) begin
      err_o <= 1'b1;
    end
  end

  // Out-of-range stages must not trust the generator, so their twiddles are forced to zero here.
  for (genvar k = 0; k < WN_LEN; k++) begin : g_lane
    logic signed [WN_WID-1:0] wr, wi;
    assign wr = stage_ok ? fft_wn_re_i[k*WN_WID +: WN_WID] : '0;
    assign wi = stage_ok ? fft_wn_im_i[k*WN_WID +: WN_WID] : '0;

    fft_cmul_lane #(
      .WN_WID (WN_WID),
      .DAT_WID(DAT_WID)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (!stall),
      .xr   (s0_re[k*DAT_WID +: DAT_WID]),
      .xi   (s0_im[k*DAT_WID +: DAT_WID]),
      .wr   (wr),
      .wi   (wi),
      .yr   (out_re_o[k*DAT_WID +: DAT_WID]),
      .yi   (out_im_o[k*DAT_WID +: DAT_WID])
    );
  end

endmodule

// File: tb/tb_fft_wn_mul.sv
// Scoreboard bench for fft_wn_mul with a behavioural twiddle generator.
// Honours FFT_ROUND_EN in its reference arithmetic.
module tb_fft_wn_mul;

  localparam int L  = 8;
  localparam int WW = 10;
  localparam int DW = 16;
  localparam int SG = 3;
  localparam real PI = 3.14159265358979323846;

  typedef logic [L*DW-1:0] vec_t;
  typedef struct {
    vec_t re;
    vec_t im;
    int   acc;
    bit   lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_vld_i;
  logic          in_rdy_o;
  logic [SG-1:0] stage_i;
  vec_t          dat_re_i, dat_im_i;
  logic [SG-1:0] fft_stage_o;
  logic [L*WW-1:0] fft_wn_re_i, fft_wn_im_i;
  logic          out_vld_o;
  logic          out_rdy_i;
  vec_t          out_re_o, out_im_o;
  logic          err_o;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   stall_from = 0;
  int   stall_to = 0;
  bit   was_stalled = 0;
  vec_t held_re, held_im;

  fft_wn_mul dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_vld_i   (in_vld_i),
    .in_rdy_o   (in_rdy_o),
    .stage_i    (stage_i),
    .dat_re_i   (dat_re_i),
    .dat_im_i   (dat_im_i),
    .fft_stage_o(fft_stage_o),
    .fft_wn_re_i(fft_wn_re_i),
    .fft_wn_im_i(fft_wn_im_i),
    .out_vld_o  (out_vld_o),
    .out_rdy_i  (out_rdy_i),
    .out_re_o   (out_re_o),
    .out_im_o   (out_im_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Q8 twiddle exp(-j*pi*k/2^s); illegal stages return junk the DUT must ignore.
  function automatic int twid(input int s, input int k, input bit im);
    real a, v;
    if (s > 3) return im ? -37 : 100 + k;
    a = (s == 0) ? 0.0 : PI * k / (2.0 ** s);
    v = im ? -$sin(a) : $cos(a);
    return (v >= 0.0) ? $rtoi(v * 256.0 + 0.5) : -$rtoi(-v * 256.0 + 0.5);
  endfunction

  always_comb begin
    fft_wn_re_i = '0;
    fft_wn_im_i = '0;
    for (int k = 0; k < L; k++) begin
      fft_wn_re_i[k*WW +: WW] = WW'(twid(int'(fft_stage_o), k, 1'b0));
      fft_wn_im_i[k*WW +: WW] = WW'(twid(int'(fft_stage_o), k, 1'b1));
    end
  end

  function automatic int scaleSat(input longint v);
    longint r;
    r = v;
`ifdef FFT_ROUND_EN
    r = r + 128;
`endif
    r = r >>> 8;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  task automatic modelBeat(input int s, input vec_t xre, input vec_t xim,
                           output vec_t ore, output vec_t oim);
    int xr, xi, wr, wi;
    ore = '0;
    oim = '0;
    for (int k = 0; k < L; k++) begin
      xr = int'($signed(xre[k*DW +: DW]));
      xi = int'($signed(xim[k*DW +: DW]));
      wr = (s > 3) ? 0 : twid(s, k, 1'b0);
      wi = (s > 3) ? 0 : twid(s, k, 1'b1);
      ore[k*DW +: DW] = DW'(scaleSat(longint'(xr) * wr - longint'(xi) * wi));
      oim[k*DW +: DW] = DW'(scaleSat(longint'(xr) * wi + longint'(xi) * wr));
    end
  endtask

  function automatic vec_t laneVec(input int k, input int v);
    vec_t r;
    r = '0;
    r[k*DW +: DW] = DW'(v);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drives one beat, holds it until accepted, and queues its expected product.
  task automatic applyStimulus(input int s, input vec_t re, input vec_t im,
                               input vec_t ere, input vec_t eim, input bit lat);
    int waited;
    waited = 0;
    in_vld_i = 1'b1;
    stage_i  = SG'(s);
    dat_re_i = re;
    dat_im_i = im;
    @(negedge clk);
    while (!in_rdy_o && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("accept", in_rdy_o, 1'b1);
    sb.push_back('{re: ere, im: eim, acc: cyc, lat: lat});
    @(posedge clk);
    #1;
    in_vld_i = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    checkOutput("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic randomBeat(input int s, input bit lat);
    vec_t re, im, ere, eim;
    for (int k = 0; k < L; k++) begin
      re[k*DW +: DW] = DW'($urandom);
      im[k*DW +: DW] = DW'($urandom);
    end
    modelBeat(s, re, im, ere, eim);
    applyStimulus(s, re, im, ere, eim, lat);
  endtask

  initial begin
    out_rdy_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_rdy_i = !(cyc >= stall_from && cyc < stall_to);
    end
  end

  // Monitor: stall behaviour and in-order delivery against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_vld_o && !out_rdy_i) begin
        checkOutput("rdy_stall", in_rdy_o, 1'b0);
        if (was_stalled) begin
          checkOutput("hold_re", out_re_o, held_re);
          checkOutput("hold_im", out_im_o, held_im);
        end
        held_re = out_re_o;
        held_im = out_im_o;
        was_stalled = 1'b1;
      end else begin
        was_stalled = 1'b0;
      end
      if (out_vld_o && out_rdy_i) begin
        if (sb.size() == 0) begin
          checkOutput("spurious", out_vld_o, 1'b0);
        end else begin
          e = sb.pop_front();
          checkOutput("out_re", out_re_o, e.re);
          checkOutput("out_im", out_im_o, e.im);
          if (e.lat) checkOutput("latency", cyc - e.acc, 3);
        end
      end
    end
  end

  initial begin
    vec_t re, im;
    rst_n    = 1'b0;
    in_vld_i = 1'b0;
    stage_i  = '0;
    dat_re_i = '0;
    dat_im_i = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_vld", out_vld_o, 1'b0);
    checkOutput("rst_rdy", in_rdy_o, 1'b1);
    checkOutput("rst_err", err_o, 1'b0);
    checkOutput("rst_stage", fft_stage_o, 0);
    checkOutput("rst_out", {out_re_o, out_im_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Unity twiddle passthrough on every lane
    for (int k = 0; k < L; k++) begin
      re[k*DW +: DW] = DW'(1000);
      im[k*DW +: DW] = DW'(-500);
    end
    applyStimulus(0, re, im, re, im, 1'b1);
    waitDrain();

    applyStimulus(1, laneVec(1, 1000), laneVec(1, -500), laneVec(1, -500), laneVec(1, -1000), 1'b1);
    waitDrain();
`ifdef FFT_ROUND_EN
    applyStimulus(2, laneVec(1, 100), '0, laneVec(1, 71), laneVec(1, -71), 1'b1);
`else
    applyStimulus(2, laneVec(1, 100), '0, laneVec(1, 70), laneVec(1, -71), 1'b1);
`endif
    waitDrain();
    applyStimulus(3, laneVec(1, 32767), laneVec(1, 32767), laneVec(1, 32767), laneVec(1, 17791), 1'b1);
    waitDrain();
    checkOutput("err_clear", err_o, 1'b0);

    // Back-to-back beats with no stall keep a 3-cycle latency each
    for (int i = 0; i < 4; i++) randomBeat(i, 1'b1);
    waitDrain();

    // Six-beat stream, output stalled during its cycles 4-6, last beat illegal stage
    stall_from = cyc + 3;
    stall_to   = cyc + 6;
    for (int i = 0; i < 6; i++) randomBeat((i < 5) ? (i % 4) : 5, 1'b0);
    checkOutput("err_set", err_o, 1'b1);
    waitDrain();
    checkOutput("err_sticky", err_o, 1'b1);
    stall_from = 0;
    stall_to   = 0;

    // Reset with two beats in flight
    randomBeat(2, 1'b0);
    randomBeat(3, 1'b0);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("inrst_vld", out_vld_o, 1'b0);
    checkOutput("inrst_rdy", in_rdy_o, 1'b1);
    checkOutput("inrst_err", err_o, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("postrst_vld", out_vld_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
